arm_sequencer: RTL and testbench
================================

ARM_SEQUENCER -- requirements
Module: arm_sequencer

Interface
- REQ-001: Parameter RESET_PC, 16'h0000, PC value loaded on reset.
- REQ-002: Clocking is fixed: one clock; reset is synchronous and active-high.
- REQ-003: clk  input  1  sole clock; all state changes on rising edge.
- REQ-004: rst  input  1  synchronous active-high reset.
- REQ-005: imem_data  input  16  instruction word at imem_addr.
- REQ-006: imem_ready  input  1  imem_data valid this cycle.
- REQ-007: dmem_ready  input  1  load data valid this cycle, sampled in EXEC2 only.
- REQ-008: imem_addr  output  16  equals pc at all times.
- REQ-009: inst  output  16  instruction register, drives ALU inst input.
- REQ-010: state  output  3  one-hot phase to ALU: FETCH=001, EXEC1=010, EXEC2=100, HALT=000.
- REQ-011: pc  output  16  program counter.
- REQ-012: halted  output  1  high while in HALT.
- REQ-013: retired  output  16  count of completed instructions.

Function
- REQ-014: Decode on inst: ldr = inst[15:12]==4'b1110; branch = inst[15:12]==4'b0000; halt = inst[15:12]==4'b0001; all other encodings are single-cycle ops.
- REQ-015: FETCH: if imem_ready=1, inst <= imem_data and next state EXEC1; else remain in FETCH with inst and pc unchanged.
- REQ-016: EXEC1, ldr: next state EXEC2; pc unchanged.
- REQ-017: EXEC1, halt: next state HALT; pc unchanged; retired increments.
- REQ-018: EXEC1, branch: pc <= pc + sign-extended inst[7:0] (16-bit, modulo 2^16); next state FETCH; retired increments.
- REQ-019: EXEC1, any other encoding: pc <= pc + 1 (modulo 2^16); next state FETCH; retired increments.
- REQ-020: EXEC2: if dmem_ready=1, pc <= pc + 1, retired increments, next state FETCH; else remain in EXEC2 with all registers held.
- REQ-021: HALT: absorbing; only rst leaves it; imem_ready and dmem_ready ignored.
- REQ-022: EXEC1 lasts exactly one cycle; minimum instruction latency is 2 cycles (non-ldr) or 3 cycles (ldr) with ready held high.
- REQ-023: Branch offset 8'h00 loops on the same instruction; offset 8'h80 gives pc - 128.
- REQ-024: pc and retired wrap 16'hFFFF -> 16'h0000 without error indication.
- REQ-025: state is always one of the four encodings in REQ-010; the unused encodings are never produced, and on reaching one the FSM returns to FETCH on the next edge.
- REQ-026: All outputs are registered or decoded from registered state only; no combinational path from imem_data or the ready inputs to any output.

Reset
- REQ-027: On a rising edge with rst=1: state=FETCH (001), pc=RESET_PC, inst=16'h0000, retired=0, halted=0.
- REQ-028: rst in any state, including mid-EXEC2 wait or HALT, overrides all other transitions on that edge; the in-flight instruction is not retired.
- REQ-029: The first fetch after reset is from RESET_PC on the first edge with rst=0 and imem_ready=1.

Verification
- REQ-030: Reset then imem_data=16'h8000 (add), ready high -> state 001,010,001; pc 0->1; retired=1 after 2 cycles.
- REQ-031: Fetch 16'hE000 (ldr), dmem_ready low 3 cycles then high -> EXEC2 held 4 cycles; pc 0->1 only on ready; retired increments once.
- REQ-032: Branch 16'h00FE at pc=16'h0010 -> pc=16'h000E; branch 16'h0005 at pc=16'hFFFE -> pc=16'h0003.
- REQ-033: imem_ready low 5 cycles in FETCH -> state stays 001, inst and pc unchanged; proceeds on first ready.
- REQ-034: Fetch 16'h1000 (halt) -> state 000, halted=1 indefinitely with ready toggling; rst -> state 001, pc=RESET_PC, halted=0.
- REQ-035: rst asserted during EXEC2 wait -> next edge state 001, pc=RESET_PC, retired=0.

Source files
------------

// File: rtl/arm_seq_if.sv
// Bundle of instruction/data memory handshakes and sequencer status outputs.
// The master modport is the sequencer side; the slave modport is the environment side.
interface arm_seq_if;
    logic [15:0] imem_data;
    logic        imem_ready;
    logic        dmem_ready;
    logic [15:0] imem_addr;
    logic [15:0] inst;
    logic [2:0]  state;
    logic [15:0] pc;
    logic        halted;
    logic [15:0] retired;

    modport master (
        input  imem_data, imem_ready, dmem_ready,
        output imem_addr, inst, state, pc, halted, retired
    );

    modport slave (
        output imem_data, imem_ready, dmem_ready,
        input  imem_addr, inst, state, pc, halted, retired
    );
endinterface

// File: rtl/arm_sequencer.sv
// Multi-cycle instruction sequencer: fetch, one or two execute phases, and an absorbing halt.
// Every output is a register or a decode of registered state.
module arm_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic       clk,
    input  logic       rst,
    arm_seq_if.master  bus
);

    // One-hot phase encoding seen by the ALU; HALT is all-zero.
    typedef enum logic [2:0] {
        S_HALT  = 3'b000,
        S_FETCH = 3'b001,
        S_EXEC1 = 3'b010,
        S_EXEC2 = 3'b100
    } state_t;

    localparam logic [3:0] OP_BRANCH = 4'b0000;
    localparam logic [3:0] OP_HALT   = 4'b0001;
    localparam logic [3:0] OP_LDR    = 4'b1110;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] retired_q, retired_d;

    logic is_ldr, is_branch, is_halt;
    logic [15:0] branch_offset;

    assign is_ldr        = (inst_q[15:12] == OP_LDR);
    assign is_branch     = (inst_q[15:12] == OP_BRANCH);
    assign is_halt       = (inst_q[15:12] == OP_HALT);
    assign branch_offset = {{8{inst_q[7]}}, inst_q[7:0]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= 16'h0000;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        // NOTE: hold-by-default assignments first, so no path leaves a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        retired_d = retired_q;

        case (state_q)
            S_FETCH: begin
                if (bus.imem_ready) begin
                    inst_d  = bus.imem_data;
                    state_d = S_EXEC1;
                end
            end
            S_EXEC1: begin
                if (is_ldr) begin
                    state_d = S_EXEC2;
                end else if (is_halt) begin
                    state_d   = S_HALT;
                    retired_d = retired_q + 16'd1;
                end else if (is_branch) begin
                    pc_d      = pc_q + branch_offset;
                    retired_d = retired_q + 16'd1;
                    state_d   = S_FETCH;
                end else begin
                    pc_d      = pc_q + 16'd1;
                    retired_d = retired_q + 16'd1;
                    state_d   = S_FETCH;
                end
            end
            S_EXEC2: begin
                if (bus.dmem_ready) begin
                    pc_d      = pc_q + 16'd1;
                    retired_d = retired_q + 16'd1;
                    state_d   = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                // Illegal encodings recover to a fresh fetch.
                state_d = S_FETCH;
            end
        endcase
    end

    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.inst      = inst_q;
    assign bus.state     = state_q;
    assign bus.retired   = retired_q;
    assign bus.halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_arm_sequencer.sv
// Directed-vector bench: stimulus pushes the expected post-edge snapshot into a
// scoreboard queue; a monitor on the falling edge pops and compares it.
module tb_arm_sequencer;

    typedef struct packed {
        logic [2:0]  state;
        logic [15:0] addr;
        logic [15:0] pc;
        logic [15:0] inst;
        logic [15:0] retired;
        logic        halted;
    } snap_t;

    localparam logic [2:0] ST_F  = 3'b001;
    localparam logic [2:0] ST_E1 = 3'b010;
    localparam logic [2:0] ST_E2 = 3'b100;
    localparam logic [2:0] ST_H  = 3'b000;

    logic clk;
    logic rst;
    arm_seq_if bus ();

    arm_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    snap_t exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            snap_t e;
            snap_t a;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = '{state: bus.state, addr: bus.imem_addr, pc: bus.pc, inst: bus.inst,
                  retired: bus.retired, halted: bus.halted};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got state=%b addr=%h pc=%h inst=%h retired=%h halted=%b, expected state=%b addr=%h pc=%h inst=%h retired=%h halted=%b",
                         n, a.state, a.addr, a.pc, a.inst, a.retired, a.halted,
                         e.state, e.addr, e.pc, e.inst, e.retired, e.halted);
            end
        end
    end

    // Drive inputs for one edge, then queue what the registers must hold after it.
    task automatic step(input logic r, input logic [15:0] data, input logic ir, input logic dr,
                        input logic [2:0] st, input logic [15:0] pc, input logic [15:0] inst,
                        input logic [15:0] ret, input string name);
        snap_t e;
        rst            = r;
        bus.imem_data  = data;
        bus.imem_ready = ir;
        bus.dmem_ready = dr;
        @(posedge clk);
        e = '{state: st, addr: pc, pc: pc, inst: inst, retired: ret, halted: (st == ST_H)};
        exp_q.push_back(e);
        name_q.push_back(name);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        bus.imem_data  = 16'h0000;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;

        step(1, 16'h0000, 0, 0, ST_F,  16'h0000, 16'h0000, 16'd0, "reset");

        // Single-cycle add, ready held high.
        step(0, 16'h8000, 1, 0, ST_E1, 16'h0000, 16'h8000, 16'd0, "add_fetch");
        step(0, 16'h8000, 1, 0, ST_F,  16'h0001, 16'h8000, 16'd1, "add_exec1");

        // Load with three wait cycles on dmem_ready.
        step(0, 16'hE000, 1, 0, ST_E1, 16'h0001, 16'hE000, 16'd1, "ldr_fetch");
        step(0, 16'hE000, 1, 0, ST_E2, 16'h0001, 16'hE000, 16'd1, "ldr_exec1");
        for (int i = 0; i < 3; i++)
            step(0, 16'hE000, 1, 0, ST_E2, 16'h0001, 16'hE000, 16'd1, "ldr_wait");
        step(0, 16'hE000, 1, 1, ST_F,  16'h0002, 16'hE000, 16'd2, "ldr_done");

        // Instruction memory stall: nothing moves.
        for (int i = 0; i < 5; i++)
            step(0, 16'h1234, 0, 1, ST_F, 16'h0002, 16'hE000, 16'd2, "fetch_stall");

        // Branch chain exercising sign extension and 16-bit wrap.
        step(0, 16'h000E, 1, 0, ST_E1, 16'h0002, 16'h000E, 16'd2, "br_fwd_fetch");
        step(0, 16'h000E, 1, 0, ST_F,  16'h0010, 16'h000E, 16'd3, "br_fwd");
        step(0, 16'h00FE, 1, 0, ST_E1, 16'h0010, 16'h00FE, 16'd3, "br_back_fetch");
        step(0, 16'h00FE, 1, 0, ST_F,  16'h000E, 16'h00FE, 16'd4, "br_back");
        step(0, 16'h00F0, 1, 0, ST_E1, 16'h000E, 16'h00F0, 16'd4, "br_neg_fetch");
        step(0, 16'h00F0, 1, 0, ST_F,  16'hFFFE, 16'h00F0, 16'd5, "br_wrap_neg");
        step(0, 16'h0005, 1, 0, ST_E1, 16'hFFFE, 16'h0005, 16'd5, "br_pos_fetch");
        step(0, 16'h0005, 1, 0, ST_F,  16'h0003, 16'h0005, 16'd6, "br_wrap_pos");
        step(0, 16'h0080, 1, 0, ST_E1, 16'h0003, 16'h0080, 16'd6, "br_min_fetch");
        step(0, 16'h0080, 1, 0, ST_F,  16'hFF83, 16'h0080, 16'd7, "br_min");
        step(0, 16'h0000, 1, 0, ST_E1, 16'hFF83, 16'h0000, 16'd7, "br_loop_fetch");
        step(0, 16'h0000, 1, 0, ST_F,  16'hFF83, 16'h0000, 16'd8, "br_loop");
        step(0, 16'h007C, 1, 0, ST_E1, 16'hFF83, 16'h007C, 16'd8, "br_top_fetch");
        step(0, 16'h007C, 1, 0, ST_F,  16'hFFFF, 16'h007C, 16'd9, "br_to_ffff");
        step(0, 16'h2222, 1, 0, ST_E1, 16'hFFFF, 16'h2222, 16'd9, "op_fetch");
        step(0, 16'h2222, 1, 0, ST_F,  16'h0000, 16'h2222, 16'd10, "pc_wrap");

        // Reset during an EXEC2 wait wins over a simultaneous dmem_ready.
        step(0, 16'hE000, 1, 0, ST_E1, 16'h0000, 16'hE000, 16'd10, "ldr2_fetch");
        step(0, 16'hE000, 1, 0, ST_E2, 16'h0000, 16'hE000, 16'd10, "ldr2_exec1");
        step(0, 16'hE000, 1, 0, ST_E2, 16'h0000, 16'hE000, 16'd10, "ldr2_wait");
        step(1, 16'hE000, 1, 1, ST_F,  16'h0000, 16'h0000, 16'd0,  "rst_exec2");

        // Halt is absorbing regardless of ready activity.
        step(0, 16'h3000, 1, 0, ST_E1, 16'h0000, 16'h3000, 16'd0, "op3_fetch");
        step(0, 16'h3000, 1, 0, ST_F,  16'h0001, 16'h3000, 16'd1, "op3_exec1");
        step(0, 16'h1000, 1, 0, ST_E1, 16'h0001, 16'h1000, 16'd1, "halt_fetch");
        step(0, 16'h1000, 1, 0, ST_H,  16'h0001, 16'h1000, 16'd2, "halt_enter");
        for (int i = 0; i < 6; i++)
            step(0, 16'h8000 ^ 16'(i), i[0], ~i[0], ST_H, 16'h0001, 16'h1000, 16'd2, "halt_hold");
        step(1, 16'h8000, 1, 1, ST_F,  16'h0000, 16'h0000, 16'd0, "halt_rst");
        step(0, 16'h8000, 1, 0, ST_E1, 16'h0000, 16'h8000, 16'd0, "post_rst_fetch");
        step(0, 16'h8000, 1, 0, ST_F,  16'h0001, 16'h8000, 16'd1, "post_rst_exec1");

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
